// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic        err;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_rdata, mem_ready,
    output gnt0, gnt1, done0, done1, err, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_rdata, mem_ready,
    input  gnt0, gnt1, done0, done1, err, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: last-served fairness on ties,
// operands latched at grant, per-access timeout abort, one-cycle done pulse.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] LP_TIMEOUT = 4'(TIMEOUT);

  state_t      r_state;
  logic        r_lp;
  logic        r_owner;
  logic        r_abort;
  logic [3:0]  r_cnt;
  logic [15:0] r_rdata;
  logic        r_gnt0;
  logic        r_gnt1;
  logic        r_done0;
  logic        r_done1;
  logic        r_err;
  logic        r_mem_en;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;

  logic        w_any;
  logic        w_pick1;

  assign w_any   = bus.req0 | bus.req1;
  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign w_pick1 = bus.req1 & (~bus.req0 | ~r_lp);

  // The mem_* registers double as the latched operands; they only hold
  // non-zero values while in ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_lp        <= 1'b1;
      r_owner     <= 1'b0;
      r_abort     <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner     <= w_pick1;
            r_gnt0      <= ~w_pick1;
            r_gnt1      <= w_pick1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_pick1 ? bus.we1    : bus.we0;
            r_mem_addr  <= w_pick1 ? bus.addr1  : bus.addr0;
            r_mem_wdata <= w_pick1 ? bus.wdata1 : bus.wdata0;
            r_cnt       <= LP_TIMEOUT;
            r_abort     <= 1'b0;
            r_state     <= ACCESS;
          end
        end

        ACCESS: begin
          if (bus.mem_ready) begin
            r_rdata     <= bus.mem_rdata;
            r_lp        <= r_owner;
            r_abort     <= 1'b0;
            r_err       <= 1'b0;
            r_done0     <= ~r_owner;
            r_done1     <= r_owner;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_rdata     <= '0;
              r_lp        <= r_owner;
              r_abort     <= 1'b1;
              r_err       <= 1'b1;
              r_done0     <= ~r_owner;
              r_done1     <= r_owner;
              r_mem_en    <= 1'b0;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_wdata <= '0;
              r_state     <= RESP;
            end
          end
        end

        RESP: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_err   <= 1'b0;
          r_abort <= 1'b0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus directed sequences,
// with completions matched against a queue of expected responses.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          who;
    bit          err;
    bit          chk_rd;
    logic [15:0] rd;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    bit          r0;
    bit          r1;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdv;
    int unsigned lat;
    bit          exp_w;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, 64'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err,
                             bus.mem_en, bus.mem_we}), 64'd0);
    chk({name, "_rdata"}, 64'(bus.rdata), 64'd0);
    chk({name, "_maddr"}, 64'(bus.mem_addr), 64'd0);
    chk({name, "_mwdata"}, 64'(bus.mem_wdata), 64'd0);
  endtask

  task automatic push(input bit who, input bit err, input bit chk_rd, input logic [15:0] rd);
    exp_t e;
    e.who = who; e.err = err; e.chk_rd = chk_rd; e.rd = rd;
    sbq.push_back(e);
  endtask

  // Completion monitor and per-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    chk("one_gnt", 64'(bus.gnt0 & bus.gnt1), 64'd0);
    chk("one_done", 64'(bus.done0 & bus.done1), 64'd0);
    chk("err_without_done", 64'(bus.err & ~(bus.done0 | bus.done1)), 64'd0);
    if (bus.done0 || bus.done1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none at %0t",
                 bus.done0, bus.done1, $time);
      end else begin
        e = sbq.pop_front();
        chk("done_who", 64'(bus.done1), 64'(e.who));
        chk("done_gnt", 64'(e.who ? bus.gnt1 : bus.gnt0), 64'd1);
        chk("done_err", 64'(bus.err), 64'(e.err));
        if (e.chk_rd) chk("done_rdata", 64'(bus.rdata), 64'(e.rd));
      end
    end
  end

  vec_t vt[8];

  initial begin
    int unsigned n;
    logic [15:0] ea;
    logic [15:0] ew;

    // lp is 1 when the table starts (requester 1 served last by the tie sequence).
    vt[0] = '{r0:1, r1:0, we:0, addr:16'h0010, wdata:16'h0000, rdv:16'hBEEF, lat:0, exp_w:0};
    vt[1] = '{r0:1, r1:1, we:0, addr:16'h0020, wdata:16'h0000, rdv:16'h1111, lat:1, exp_w:1};
    vt[2] = '{r0:1, r1:1, we:0, addr:16'h0030, wdata:16'h0000, rdv:16'h2222, lat:0, exp_w:0};
    vt[3] = '{r0:1, r1:0, we:1, addr:16'h0040, wdata:16'hA5A5, rdv:16'h0000, lat:2, exp_w:0};
    vt[4] = '{r0:1, r1:1, we:1, addr:16'h0050, wdata:16'h5AA5, rdv:16'h0000, lat:0, exp_w:1};
    vt[5] = '{r0:0, r1:1, we:0, addr:16'h0060, wdata:16'h0000, rdv:16'hABCD, lat:3, exp_w:1};
    vt[6] = '{r0:1, r1:1, we:0, addr:16'h0070, wdata:16'h0000, rdv:16'h0F0F, lat:4, exp_w:0};
    vt[7] = '{r0:0, r1:1, we:0, addr:16'h0080, wdata:16'h0000, rdv:16'h7777, lat:0, exp_w:1};

    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;

    // Spurious ready with no request.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero("spurious_ready");
    end
    bus.mem_ready = 1'b0;

    // Held tie after reset: grants alternate 0,1,0,1 with one IDLE between.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.addr0 = 16'h0100; bus.addr1 = 16'h0200;
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'h5A5A;
    for (int k = 0; k < 4; k++) push(bit'(k % 2), 1'b0, 1'b1, 16'h5A5A);
    for (int c = 0; c < 13; c++) begin
      int ph;
      bit who;
      ph  = c % 3;
      who = bit'((c / 3) % 2);
      chk("tie_gnt0", 64'(bus.gnt0), 64'(ph != 0 && c < 12 && !who));
      chk("tie_gnt1", 64'(bus.gnt1), 64'(ph != 0 && c < 12 && who));
      chk("tie_done0", 64'(bus.done0), 64'(ph == 2 && !who));
      chk("tie_done1", 64'(bus.done1), 64'(ph == 2 && who));
      if (ph == 1) chk("tie_maddr", 64'(bus.mem_addr), who ? 64'h200 : 64'h100);
      if (c == 11) begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      if (c < 12) tick();
    end
    clear_inputs();

    // Table-driven transactions; requester inputs are scrambled after the grant.
    for (int v = 0; v < 8; v++) begin
      bus.req0 = vt[v].r0; bus.req1 = vt[v].r1;
      bus.we0 = vt[v].we; bus.we1 = vt[v].we;
      bus.addr0 = vt[v].addr; bus.addr1 = vt[v].addr ^ 16'h8000;
      bus.wdata0 = vt[v].wdata; bus.wdata1 = ~vt[v].wdata;
      ea = vt[v].exp_w ? (vt[v].addr ^ 16'h8000) : vt[v].addr;
      ew = vt[v].exp_w ? ~vt[v].wdata : vt[v].wdata;
      push(vt[v].exp_w, 1'b0, ~vt[v].we, vt[v].rdv);
      chk("vec_idle_gnt", 64'({bus.gnt0, bus.gnt1}), 64'd0);
      tick();
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.we0 = ~vt[v].we; bus.we1 = ~vt[v].we;
      bus.addr0 = 16'hDEAD; bus.addr1 = 16'hDEAD;
      bus.wdata0 = 16'hC0DE; bus.wdata1 = 16'hC0DE;
      for (int unsigned i = 0; i <= vt[v].lat; i++) begin
        chk("vec_mem_en", 64'(bus.mem_en), 64'd1);
        chk("vec_mem_we", 64'(bus.mem_we), 64'(vt[v].we));
        chk("vec_mem_addr", 64'(bus.mem_addr), 64'(ea));
        chk("vec_mem_wdata", 64'(bus.mem_wdata), 64'(ew));
        chk("vec_gnt", 64'({bus.gnt0, bus.gnt1}), vt[v].exp_w ? 64'b01 : 64'b10);
        bus.mem_ready = (i == vt[v].lat);
        bus.mem_rdata = (i == vt[v].lat) ? vt[v].rdv : 16'hFFFF;
        tick();
      end
      bus.mem_ready = 1'b0;
      chk("vec_resp_mem_en", 64'(bus.mem_en), 64'd0);
      chk("vec_resp_gnt", 64'({bus.gnt0, bus.gnt1}), vt[v].exp_w ? 64'b01 : 64'b10);
      tick();
      chk("vec_after_gnt", 64'({bus.gnt0, bus.gnt1}), 64'd0);
    end
    clear_inputs();

    // Write with operands changed during ACCESS; lp is 1 here.
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0042; bus.wdata1 = 16'h1234;
    push(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 16'h0099; bus.wdata1 = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      chk("wr_mem_addr", 64'(bus.mem_addr), 64'h0042);
      chk("wr_mem_we", 64'(bus.mem_we), 64'd1);
      chk("wr_mem_wdata", 64'(bus.mem_wdata), 64'h1234);
      bus.mem_ready = (i == 1);
      tick();
    end
    bus.mem_ready = 1'b0;
    tick();
    clear_inputs();

    // Timeout: 15 ACCESS cycles, then aborted done0.
    bus.req0 = 1'b1; bus.addr0 = 16'h0300; bus.mem_rdata = 16'hFFFF;
    push(1'b0, 1'b1, 1'b1, 16'h0000);
    tick();
    bus.req0 = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && bus.mem_en; k++) begin
      n++;
      tick();
    end
    chk("timeout_access_cycles", 64'(n), 64'd15);
    chk("timeout_done0", 64'(bus.done0), 64'd1);
    chk("timeout_err", 64'(bus.err), 64'd1);
    tick();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 16'h3C3C;
    push(1'b1, 1'b0, 1'b1, 16'h3C3C);
    tick();
    chk("post_timeout_tie_gnt1", 64'({bus.gnt0, bus.gnt1}), 64'b01);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    clear_inputs();

    // Reset in the second ACCESS cycle abandons the access without done.
    bus.req0 = 1'b1; bus.addr0 = 16'h0400;
    tick();
    bus.req0 = 1'b0;
    tick();
    chk("rst_mid_mem_en", 64'(bus.mem_en), 64'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid_async");
    tick();
    tick();
    chk_all_zero("rst_mid_hold");
    reset = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 16'h6161;
    push(1'b0, 1'b0, 1'b1, 16'h6161);
    tick();
    chk("post_reset_tie_gnt0", 64'({bus.gnt0, bus.gnt1}), 64'b10);
    bus.req0 = 1'b0; bus.req1 = 1'b1 ^ 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    tick();

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum ACCESS cycles allowed before an abort (legal range 1..15).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  access request from requester 0 (instruction fetch) and requester 1 (data/loader).
REQ-005 we0, we1  input  1 each  write enable: 1 = write, 0 = read.
REQ-006 addr0, addr1  input  16 each  word address.
REQ-007 wdata0, wdata1  input  16 each  write data.
REQ-008 gnt0, gnt1  output  1 each  requester currently owns memory.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 err  output  1  high together with done when the access was aborted by timeout.
REQ-011 rdata  output  16  read data, valid while done0 or done1 is high.
REQ-012 mem_en, mem_we  output  1 each  memory strobe and write enable.
REQ-013 mem_addr, mem_wdata  output  16 each  memory address and write data.
REQ-014 mem_rdata  input  16  memory read data.
REQ-015 mem_ready  input  1  memory completes the current access this cycle.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-017 IDLE behaviour when any req is high:
- select a winner;
- latch the winner's we, addr and wdata into internal registers;
- load the timeout counter with TIMEOUT;
- enter ACCESS on the next edge.
REQ-018 Winner selection SHALL use the last-served bit lp:
- only one req high: that requester wins;
- both high: the requester not equal to lp wins.
REQ-019 In ACCESS:
- mem_en SHALL be 1;
- mem_we, mem_addr and mem_wdata SHALL be driven from the latched registers only, so requester input changes after the grant have no effect.
REQ-020 In ACCESS, when mem_ready is 1:
- capture mem_rdata into rdata (writes also capture; the value is don't-care);
- set lp to the served requester;
- enter RESP.
REQ-021 In ACCESS, when mem_ready is 0:
- decrement the counter;
- if the counter is 1 while mem_ready is 0, enter RESP with an abort flag set, rdata = 16'h0000, and lp updated.
REQ-022 In RESP:
- the served requester's done SHALL be 1 for exactly one cycle;
- err SHALL equal the abort flag;
- then return to IDLE.
REQ-023 gnt0/gnt1 SHALL be high from the first ACCESS cycle through the RESP cycle inclusive; at most one gnt and at most one done SHALL be high in any cycle.
REQ-024 Outside ACCESS, all of mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-025 Minimum transaction latency SHALL be 3 cycles (IDLE grant, ACCESS with mem_ready=1, RESP); the next grant is at the earliest in the cycle after RESP.
REQ-026 A req still high in the IDLE cycle after its own done SHALL count as a new request; it is subject to REQ-018, so the other requester wins if both are high.
REQ-027 A req dropped during ACCESS SHALL NOT cancel the transaction; done still pulses.
REQ-028 mem_ready asserted in IDLE or RESP SHALL be ignored.

Reset
REQ-029 While reset is low, the block SHALL force all of the following asynchronously:
- state = IDLE, lp = 1, abort flag = 0, counter = 0;
- rdata = 0;
- all gnt, done, err and mem_* outputs = 0.
REQ-030 Reset asserted mid-ACCESS or mid-RESP SHALL abandon the transaction with no done pulse.
REQ-031 After reset deasserts, the first tie SHALL be won by requester 0.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Single read: req0=1, we0=0, addr0=16'h0010, mem_ready=1 in the first ACCESS cycle with mem_rdata=16'hBEEF -> mem_en high 1 cycle with mem_addr=16'h0010; done0 plus rdata=16'hBEEF on cycle 3; err=0.
- Tie after reset: req0=req1=1 held -> grants alternate 0,1,0,1; each done is 3 cycles apart, with 1 IDLE cycle between transactions.
- Write with latched operands: req1, we1=1, addr1=16'h0042, wdata1=16'h1234, then addr1 changed to 16'h0099 during ACCESS; mem_ready after 2 cycles -> mem_addr stays 16'h0042, mem_we=1 and mem_wdata=16'h1234 for both cycles; then done1.
- Timeout: TIMEOUT=15 with mem_ready held at 0 -> 15 ACCESS cycles, then done0=1, err=1, rdata=0; the next tie goes to requester 1.
- Reset mid-ACCESS: reset low in the 2nd ACCESS cycle -> all outputs 0 immediately and no done pulse; after release, a tie grants requester 0.
- Spurious ready: mem_ready=1 in IDLE with no req -> no state change and all outputs remain 0.
